scoreboard_hazard_unit: RTL and testbench
=========================================

// Module: scoreboard_hazard_unit
// PURPOSE
//   Parametrised hazard-detection unit for the in-order MIPS pipeline, sitting beside the ID stage.
//   Holds a per-register ready countdown (scoreboard) instead of comparing against a single ID/EX slot.
//   From that countdown it decides load-use stalls and branch-in-ID stalls (1 after ALU, 2 after load).
//   Also drives PC/IF-ID write enables, the ID/EX bubble, and a saturating stall-cycle counter.
// PARAMETERS
//   NUM_REGS     32  architectural registers; register 0 is hard-wired zero and never tracked
//   REG_ADDR_W   5   register address width (2**REG_ADDR_W >= NUM_REGS)
//   ALU_LAT      1   cycles after issue until an ALU result is forwardable to ID; range 1..7
//   LOAD_LAT     2   cycles after issue until a load result is forwardable to ID; LOAD_LAT >= ALU_LAT, <= 7
//   BRANCH_IN_ID 1   1: branch operands are needed in ID; 0: branches are checked like normal consumers
//   STAT_W       32  width of stall_cycles
// PORTS
//   clk           in   1           clock, rising edge
//   rst           in   1           asynchronous reset, active-high
//   id_valid      in   1           ID holds a real instruction
//   id_flush      in   1           ID instruction is being squashed this cycle (taken branch/jump)
//   id_rs         in   REG_ADDR_W  first source register
//   id_rs_used    in   1           instruction reads id_rs
//   id_rt         in   REG_ADDR_W  second source register
//   id_rt_used    in   1           instruction reads id_rt
//   id_is_branch  in   1           instruction is beq/bne (resolved in ID)
//   id_reg_write  in   1           instruction writes id_rd
//   id_mem_read   in   1           instruction is a load (uses LOAD_LAT)
//   id_rd         in   REG_ADDR_W  destination register
//   stall         out  1           hold PC and IF/ID, insert bubble into ID/EX
//   pc_write      out  1           = ~stall
//   if_id_write   out  1           = ~stall
//   id_ex_bubble  out  1           = stall | id_flush; zero control signals into ID/EX
//   stall_cycles  out  STAT_W      count of cycles with stall=1, saturating at all-ones
// BEHAVIOUR
//   - State: cnt[r] for r = 1..NUM_REGS-1, width CW = $clog2(LOAD_LAT+1). stall_cycles is the only other state.
//   - Reset (async, while rst=1): all cnt = 0, stall_cycles = 0.
//     Hence stall = 0, pc_write = 1, if_id_write = 1, id_ex_bubble = id_flush.
//   - Need level: need = (BRANCH_IN_ID && id_is_branch) ? 0 : 1.
//     The source is blocked when used, nonzero, and cnt[src] > need.
//   - stall = id_valid & ~id_flush & (blocked(rs) | blocked(rt)); purely combinational, same-cycle.
//     rs == rt is checked once (identical result).
//     Source 0 never blocks.
//   - issue = id_valid & ~id_flush & ~stall & id_reg_write & (id_rd != 0).
//   - On every rising edge, per register r:
//       if issue && id_rd == r: cnt[r] <= id_mem_read ? LOAD_LAT : ALU_LAT
//       else if cnt[r] != 0:    cnt[r] <= cnt[r] - 1
//   - Issue overwrites any nonzero count; the youngest producer wins, matching youngest-first forwarding.
//   - Issue beats decrement on the same register in the same edge.
//   - Counters keep decrementing during stall and flush; stall is self-releasing, with no deadlock possible.
//   - Resulting stalls (defaults), producer followed immediately by consumer:
//       ALU->ALU 0, load->ALU 1, ALU->branch 1, load->branch 2, load->(1 gap)->branch 1.
//   - stall_cycles increments on each edge where stall=1, unless already all-ones.
//   - Reset asserted mid-stall: stall drops asynchronously with rst; no pending count survives.
//   - id_valid=0: no stall, no issue; counters still age.
// TESTING
//   1 reset: rst=1 mid-operation -> stall=0, pc_write=1, stall_cycles=0 immediately; all cnt=0 after release.
//   2 lw $2 ; add $3,$2,$4 -> exactly 1 cycle stall=1, id_ex_bubble=1, then add issues; stall_cycles=1.
//   3 add $2 ; beq $2,$5 -> 1 stall. lw $2 ; beq $2,$5 -> 2 stalls.
//     Same with BRANCH_IN_ID=0 -> 0 and 1 stalls.
//   4 lw $0 ; add $3,$0,$0 -> 0 stalls. lw $2 with id_flush=1 ; add $3,$2,$2 -> 0 stalls.
//   5 lw $2 ; add $2,$1,$1 ; beq $2,$2 -> load stalls nothing (add uses $1).
//     The add overwrites cnt[2]=1, then beq stalls 1, not 2.
//   6 LOAD_LAT=4, ALU_LAT=2: lw $7 ; add $8,$7,$7 -> 3 stalls.
//     Hold stall for 2**STAT_W cycles with STAT_W=4 -> stall_cycles saturates at 15.

Source files
------------

// File: rtl/scoreboard_hazard_unit.sv
// Scoreboard-based hazard unit for the in-order MIPS pipeline: per-register
// ready countdowns drive load-use and branch-in-ID stalls plus a stall counter.
module scoreboard_hazard_unit #(
   parameter int NUM_REGS     = 32,
   parameter int REG_ADDR_W   = 5,
   parameter int ALU_LAT      = 1,
   parameter int LOAD_LAT     = 2,
   parameter int BRANCH_IN_ID = 1,
   parameter int STAT_W       = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic                  id_flush,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic                  id_rs_used,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_rt_used,
   input  logic                  id_is_branch,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic [REG_ADDR_W-1:0] id_rd,
   output logic                  stall,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  id_ex_bubble,
   output logic [STAT_W-1:0]     stall_cycles
);

   localparam int CW = $clog2(LOAD_LAT + 1);
   localparam logic [CW-1:0]       ALU_C  = CW'(ALU_LAT);
   localparam logic [CW-1:0]       LOAD_C = CW'(LOAD_LAT);
   localparam logic [REG_ADDR_W:0] NREGS  = (REG_ADDR_W + 1)'(NUM_REGS);

   logic [CW-1:0] cnt [NUM_REGS];
   logic [CW-1:0] need;
   logic [CW-1:0] rs_cnt;
   logic [CW-1:0] rt_cnt;
   logic          rs_blocked;
   logic          rt_blocked;
   logic          issue;

   // Branches resolved in ID need the value one cycle earlier than a normal consumer.
   always_comb begin
      need       = (BRANCH_IN_ID != 0 && id_is_branch) ? '0 : CW'(1);
      rs_cnt     = ({1'b0, id_rs} < NREGS) ? cnt[id_rs] : '0;
      rt_cnt     = ({1'b0, id_rt} < NREGS) ? cnt[id_rt] : '0;
      rs_blocked = id_rs_used && (id_rs != '0) && (rs_cnt > need);
      rt_blocked = id_rt_used && (id_rt != '0) && (rt_cnt > need);
      stall      = id_valid && !id_flush && (rs_blocked || rt_blocked);
      issue      = id_valid && !id_flush && !stall && id_reg_write && (id_rd != '0);
   end

   assign pc_write     = ~stall;
   assign if_id_write  = ~stall;
   assign id_ex_bubble = stall | id_flush;

   // Youngest producer overwrites any pending count; others age toward zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      end else begin
         cnt[0] <= '0;
         for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (issue && id_rd == REG_ADDR_W'(r))
               cnt[r] <= id_mem_read ? LOAD_C : ALU_C;
            else if (cnt[r] != '0)
               cnt[r] <= cnt[r] - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cycles <= '0;
      else if (stall && stall_cycles != '1)
         stall_cycles <= stall_cycles + STAT_W'(1);
   end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Self-checking bench: three parameterisations share one stimulus stream and are
// compared every cycle against a timestamp-based readiness model.
module tb_scoreboard_hazard_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_flush, id_rs_used, id_rt_used;
   logic       id_is_branch, id_reg_write, id_mem_read;
   logic [4:0] id_rs, id_rt, id_rd;

   logic        st [3];
   logic        pw [3];
   logic        iw [3];
   logic        bb [3];
   logic [31:0] sc0, sc1;
   logic [3:0]  sc2;

   always #5 clk = ~clk;

   scoreboard_hazard_unit #(.NUM_REGS(32), .REG_ADDR_W(5), .ALU_LAT(1), .LOAD_LAT(2),
                            .BRANCH_IN_ID(1), .STAT_W(32)) dut0 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_flush(id_flush),
      .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
      .id_is_branch(id_is_branch), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_rd(id_rd), .stall(st[0]), .pc_write(pw[0]), .if_id_write(iw[0]),
      .id_ex_bubble(bb[0]), .stall_cycles(sc0));

   scoreboard_hazard_unit #(.NUM_REGS(32), .REG_ADDR_W(5), .ALU_LAT(1), .LOAD_LAT(2),
                            .BRANCH_IN_ID(0), .STAT_W(32)) dut1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_flush(id_flush),
      .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
      .id_is_branch(id_is_branch), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_rd(id_rd), .stall(st[1]), .pc_write(pw[1]), .if_id_write(iw[1]),
      .id_ex_bubble(bb[1]), .stall_cycles(sc1));

   scoreboard_hazard_unit #(.NUM_REGS(32), .REG_ADDR_W(5), .ALU_LAT(2), .LOAD_LAT(4),
                            .BRANCH_IN_ID(1), .STAT_W(4)) dut2 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_flush(id_flush),
      .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
      .id_is_branch(id_is_branch), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_rd(id_rd), .stall(st[2]), .pc_write(pw[2]), .if_id_write(iw[2]),
      .id_ex_bubble(bb[2]), .stall_cycles(sc2));

   int checks = 0;
   int errors = 0;

   // Model: each register records the cycle number at which its value becomes
   // forwardable; the remaining wait is that cycle minus the current cycle.
   longint          now = 0;
   longint          ready_at [3][32];
   longint unsigned sc_m [3];
   int              alat [3] = '{1, 1, 2};
   int              llat [3] = '{2, 2, 4};
   int              bid  [3] = '{1, 0, 1};
   longint unsigned smax [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
   logic            obs_stall [3];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] get_sc(input int d);
      case (d)
         0:       return sc0;
         1:       return sc1;
         default: return {28'd0, sc2};
      endcase
   endfunction

   function automatic bit m_blocked(input int d, input logic [4:0] src, input logic used);
      longint need = (bid[d] != 0 && id_is_branch) ? 0 : 1;
      return used && src != 0 && (ready_at[d][src] - now) > need;
   endfunction

   function automatic bit m_stall(input int d);
      return !rst && id_valid && !id_flush &&
             (m_blocked(d, id_rs, id_rs_used) || m_blocked(d, id_rt, id_rt_used));
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         sc_m[d] = 0;
         for (int r = 0; r < 32; r++) ready_at[d][r] = 0;
      end
   endtask

   task automatic do_cycle();
      bit es;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         es = m_stall(d);
         check($sformatf("stall[%0d]", d), st[d], es);
         check($sformatf("pc_write[%0d]", d), pw[d], !es);
         check($sformatf("if_id_write[%0d]", d), iw[d], !es);
         check($sformatf("id_ex_bubble[%0d]", d), bb[d], es || id_flush);
         check($sformatf("stall_cycles[%0d]", d), get_sc(d), sc_m[d][31:0]);
         obs_stall[d] = st[d];
      end
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         for (int d = 0; d < 3; d++) begin
            es = m_stall(d);
            if (es && sc_m[d] != smax[d]) sc_m[d]++;
            if (id_valid && !id_flush && !es && id_reg_write && id_rd != 0)
               ready_at[d][id_rd] = now + 1 + (id_mem_read ? llat[d] : alat[d]);
         end
      end
      now++;
      #1;
   endtask

   task automatic set_in(input logic v, input logic fl, input logic br, input logic rw,
                         input logic mr, input logic [4:0] rd, input logic [4:0] rs,
                         input logic rsu, input logic [4:0] rt, input logic rtu);
      id_valid = v; id_flush = fl; id_is_branch = br; id_reg_write = rw;
      id_mem_read = mr; id_rd = rd; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
   endtask

   // Present one instruction and hold it until DUT d stops stalling; n = stall cycles.
   task automatic exec(input int d, input logic fl, input logic br, input logic rw,
                       input logic mr, input logic [4:0] rd, input logic [4:0] rs,
                       input logic rsu, input logic [4:0] rt, input logic rtu, output int n);
      set_in(1'b1, fl, br, rw, mr, rd, rs, rsu, rt, rtu);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         do_cycle();
         if (!obs_stall[d]) break;
         n++;
      end
   endtask

   task automatic idle(input int cycles);
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      for (int i = 0; i < cycles; i++) do_cycle();
   endtask

   initial begin
      int n;
      model_reset();
      rst = 1'b1;
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      do_cycle();
      do_cycle();
      rst = 1'b0;
      idle(2);

      // load -> dependent ALU: one stall, counted once
      exec(0, 0, 0, 1, 1, 5'd2, 5'd0, 0, 5'd0, 0, n);
      exec(0, 0, 0, 1, 0, 5'd3, 5'd2, 1, 5'd4, 1, n);
      check("lw_add_stalls", n, 1);
      check("lw_add_stall_cycles", sc0, 1);
      idle(6);

      // ALU/load -> branch, branch-in-ID and not
      exec(0, 0, 0, 1, 0, 5'd2, 5'd1, 1, 5'd1, 1, n);
      exec(0, 0, 1, 0, 0, 5'd0, 5'd2, 1, 5'd5, 1, n);
      check("alu_beq_stalls", n, 1);
      idle(6);
      exec(0, 0, 0, 1, 1, 5'd2, 5'd0, 0, 5'd0, 0, n);
      exec(0, 0, 1, 0, 0, 5'd0, 5'd2, 1, 5'd5, 1, n);
      check("lw_beq_stalls", n, 2);
      idle(6);
      exec(1, 0, 0, 1, 0, 5'd2, 5'd1, 1, 5'd1, 1, n);
      exec(1, 0, 1, 0, 0, 5'd0, 5'd2, 1, 5'd5, 1, n);
      check("alu_beq_noid_stalls", n, 0);
      idle(6);
      exec(1, 0, 0, 1, 1, 5'd2, 5'd0, 0, 5'd0, 0, n);
      exec(1, 0, 1, 0, 0, 5'd0, 5'd2, 1, 5'd5, 1, n);
      check("lw_beq_noid_stalls", n, 1);
      idle(6);

      // register 0 and flushed producers never create hazards
      exec(0, 0, 0, 1, 1, 5'd0, 5'd0, 0, 5'd0, 0, n);
      exec(0, 0, 0, 1, 0, 5'd3, 5'd0, 1, 5'd0, 1, n);
      check("lw_r0_stalls", n, 0);
      idle(6);
      exec(0, 1, 0, 1, 1, 5'd2, 5'd0, 0, 5'd0, 0, n);
      exec(0, 0, 0, 1, 0, 5'd3, 5'd2, 1, 5'd2, 1, n);
      check("flushed_lw_stalls", n, 0);
      idle(6);

      // younger ALU producer overrides the load countdown
      exec(0, 0, 0, 1, 1, 5'd2, 5'd0, 0, 5'd0, 0, n);
      exec(0, 0, 0, 1, 0, 5'd2, 5'd1, 1, 5'd1, 1, n);
      check("override_add_stalls", n, 0);
      exec(0, 0, 1, 0, 0, 5'd0, 5'd2, 1, 5'd2, 1, n);
      check("override_beq_stalls", n, 1);
      idle(6);

      // long latencies and counter saturation on the narrow instance
      exec(2, 0, 0, 1, 1, 5'd7, 5'd0, 0, 5'd0, 0, n);
      exec(2, 0, 0, 1, 0, 5'd8, 5'd7, 1, 5'd7, 1, n);
      check("lat4_lw_add_stalls", n, 3);
      for (int k = 0; k < 6; k++) begin
         exec(2, 0, 0, 1, 1, 5'd7, 5'd0, 0, 5'd0, 0, n);
         exec(2, 0, 0, 1, 0, 5'd8, 5'd7, 1, 5'd7, 1, n);
      end
      check("stat4_saturated", {28'd0, sc2}, 32'd15);
      idle(6);

      // asynchronous reset in the middle of a stall
      exec(0, 0, 0, 1, 1, 5'd2, 5'd0, 0, 5'd0, 0, n);
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 5'd2, 1'b1, 5'd4, 1'b1);
      @(negedge clk);
      check("pre_reset_stall", st[0], 1'b1);
      #2 rst = 1'b1;
      #1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("rst_stall[%0d]", d), st[d], 1'b0);
         check($sformatf("rst_pc_write[%0d]", d), pw[d], 1'b1);
         check($sformatf("rst_stall_cycles[%0d]", d), get_sc(d), 32'd0);
      end
      model_reset();
      @(posedge clk);
      now++;
      #1 rst = 1'b0;
      do_cycle();
      idle(6);

      // randomized traffic over a small register window to provoke hazards
      for (int i = 0; i < 400; i++) begin
         set_in($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                5'($urandom_range(0, 7)), $urandom_range(0, 1) != 0);
         do_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
